// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// default field widths used by the receiver and its payload counter.
package serial_frame_receiver_pkg;

  localparam int PORT_W_DEF = 2;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/serial_frame_receiver_payload_counter.sv
// Payload down-counter: loaded with the frame length, decremented once per
// delivered payload bit, saturating at zero so it can never wrap.
module payload_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         is_one_o
);

  logic [W-1:0] count_q;

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit (0), PORT_W-bit destination port, LEN_W-bit
// payload length (both MSB-first), then `length` payload bits. Each payload bit
// is presented one cycle after it is sampled, strobed on data_valid[port_id].
// After the last payload bit is presented the FSM spends one cycle in DONE
// (done=1, busy=0) while ignoring the line, then returns to IDLE.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [PORT_W-1:0]    port_id,
  output logic [LEN_W-1:0]     length,
  output logic                 data_out,
  output logic [2**PORT_W-1:0] data_valid,
  output logic                 last_bit,
  output logic                 busy,
  output logic                 done
);

  localparam int NPORT   = 2**PORT_W;
  localparam int HDR_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int CNT_W   = $clog2(HDR_MAX + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [PORT_W-1:0]  port_id_q;
  logic [LEN_W-1:0]   length_q;
  logic               data_out_q;
  logic [NPORT-1:0]   data_valid_q;
  logic               last_bit_q;
  logic               busy_q;
  logic               done_q;

  logic [PORT_W-1:0]  port_d;
  logic [LEN_W-1:0]   len_d;
  logic [NPORT-1:0]   valid_d;
  logic               port_last;
  logic               len_last;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [LEN_W-1:0]   cnt;
  logic               cnt_is_one;

  // Header shift candidates, field-end detection and counter controls.
  always_comb begin
    port_d    = (port_id_q << 1) | PORT_W'(serial_in);
    len_d     = (length_q << 1) | LEN_W'(serial_in);
    valid_d   = NPORT'(1) << port_id_q;
    port_last = (bit_cnt_q == CNT_W'(PORT_W - 1));
    len_last  = (bit_cnt_q == CNT_W'(LEN_W - 1));
    cnt_zero  = (cnt == '0);
    cnt_load  = (state_q == ST_LEN) && len_last && (len_d != '0);
    cnt_dec   = (state_q == ST_DATA) && !cnt_zero;
  end

  payload_counter #(
    .W (LEN_W)
  ) u_payload_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (len_d),
    .dec_i      (cnt_dec),
    .count_o    (cnt),
    .is_one_o   (cnt_is_one)
  );

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      port_id_q    <= '0;
      length_q     <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= '0;
      last_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      data_valid_q <= '0;
      last_bit_q   <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!serial_in) begin
            state_q   <= ST_PORT;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_PORT: begin
          port_id_q <= port_d;
          if (port_last) begin
            state_q   <= ST_LEN;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        ST_LEN: begin
          length_q <= len_d;
          if (len_last) begin
            bit_cnt_q <= '0;
            if (len_d != '0) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          // Counter at zero means the final bit is already on data_out.
          if (!cnt_zero) begin
            data_out_q   <= serial_in;
            data_valid_q <= valid_d;
            last_bit_q   <= cnt_is_one;
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign port_id    = port_id_q;
  assign length     = length_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_serial_frame_receiver;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 8;

  logic                 clk;
  logic                 rst;
  logic                 serial_in;
  logic [PORT_W-1:0]    port_id;
  logic [LEN_W-1:0]     length;
  logic                 data_out;
  logic [2**PORT_W-1:0] data_valid;
  logic                 last_bit;
  logic                 busy;
  logic                 done;

  int n_cmp = 0;
  int n_err = 0;

  serial_frame_receiver #(
    .PORT_W (PORT_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .port_id    (port_id),
    .length     (length),
    .data_out   (data_out),
    .data_valid (data_valid),
    .last_bit   (last_bit),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l);
    send_bit(1'b0);
    for (int i = PORT_W - 1; i >= 0; i--) send_bit(p[i]);
    for (int i = LEN_W - 1; i >= 0; i--) send_bit(l[i]);
  endtask

  initial begin
    int  nv;
    int  nl;
    int  bad;
    logic saw_done;

    // Reset state
    rst = 1'b1;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {port_id, length, data_out, data_valid, last_bit, done}, 0);
    rst = 1'b0;

    // Idle line for 20 cycles
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      if (busy !== 1'b0 || data_valid !== '0 || done !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Frame: port 2, length 3, payload 1,0,1
    send_hdr(2'b10, 8'd3);
    chk("f1_port", port_id, 2);
    chk("f1_len", length, 3);
    chk("f1_busy", busy, 1);
    chk("f1_dv_pre", data_valid, 0);
    send_bit(1'b1);
    chk("f1_b0", {data_valid, data_out, last_bit, done}, {4'b0100, 1'b1, 1'b0, 1'b0});
    send_bit(1'b0);
    chk("f1_b1", {data_valid, data_out, last_bit, done}, {4'b0100, 1'b0, 1'b0, 1'b0});
    send_bit(1'b1);
    chk("f1_b2", {data_valid, data_out, last_bit, done}, {4'b0100, 1'b1, 1'b1, 1'b0});
    send_bit(1'b1);
    chk("f1_done", {data_valid, last_bit, done, busy}, {4'b0000, 1'b0, 1'b1, 1'b0});
    send_bit(1'b1);
    chk("f1_idle", {done, busy}, 0);
    chk("f1_hold", {port_id, length}, {2'd2, 8'd3});

    // Zero length: port 1
    send_hdr(2'b01, 8'd0);
    chk("z_done", {data_valid, done, busy}, {4'b0000, 1'b1, 1'b0});
    chk("z_port", port_id, 1);
    send_bit(1'b1);
    chk("z_idle", {data_valid, done, busy}, 0);

    // Back-to-back: port 1 length 1 payload 0, 0 on DONE cycle, then new frame
    send_hdr(2'b01, 8'd1);
    send_bit(1'b0);
    chk("bb_a_bit", {data_valid, data_out, last_bit}, {4'b0010, 1'b0, 1'b1});
    send_bit(1'b0);
    chk("bb_a_done", {done, busy}, {1'b1, 1'b0});
    send_bit(1'b0);
    chk("bb_ignored", {done, busy}, 0);
    send_hdr(2'b11, 8'd2);
    chk("bb_b_hdr", {port_id, length}, {2'd3, 8'd2});
    send_bit(1'b1);
    chk("bb_b_b0", {data_valid, data_out, last_bit}, {4'b1000, 1'b1, 1'b0});
    send_bit(1'b1);
    chk("bb_b_b1", {data_valid, data_out, last_bit}, {4'b1000, 1'b1, 1'b1});
    send_bit(1'b1);
    chk("bb_b_done", done, 1);
    send_bit(1'b1);

    // Mid-frame reset during third of 5 payload bits
    send_hdr(2'b01, 8'd5);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mr_pre", data_valid, 4'b0010);
    serial_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_clear", {port_id, length, data_out, data_valid, last_bit, busy, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mr_no_done", bad, 0);
    send_hdr(2'b11, 8'd2);
    chk("mr_hdr", {port_id, length}, {2'd3, 8'd2});
    send_bit(1'b0);
    chk("mr_b0", {data_valid, data_out, last_bit}, {4'b1000, 1'b0, 1'b0});
    send_bit(1'b1);
    chk("mr_b1", {data_valid, data_out, last_bit}, {4'b1000, 1'b1, 1'b1});
    send_bit(1'b1);
    chk("mr_done", done, 1);
    send_bit(1'b1);

    // Maximum length 255 on port 0
    send_hdr(2'b00, 8'd255);
    nv = 0;
    nl = 0;
    bad = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send_bit(logic'(i % 2));
      if (data_valid !== '0) begin
        nv++;
        if (data_valid !== 4'b0001 || data_out !== logic'(i % 2)) bad++;
      end
      if (last_bit === 1'b1) nl++;
      if (done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
    end
    chk("max_valid_cnt", nv, 255);
    chk("max_last_cnt", nl, 1);
    chk("max_data", bad, 0);
    chk("max_done", saw_done, 1);
    send_bit(1'b1);
    chk("max_idle", {busy, done, data_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
